seg7_feed_scheduler: RTL and testbench

- Shares the single character-entry path of the 8-digit 7-segment display between NUM_REQ independent producers, e.g. keypad decoder, UART receiver and status-message ROM.
- Grants one requester at a time, round-robin.
- Converts each accepted word into a well-formed char_valid (or clear) pulse followed by a guaranteed low gap, so the display's rising-edge detector sees exactly one event per word.
- Sits between the producers and the display controller, in the same clk domain.

---
 rtl/seg7_feed_scheduler_pkg.sv | 18 +
 rtl/seg7_feed_scheduler_rr_arbiter.sv | 31 +++
 rtl/seg7_feed_scheduler.sv | 135 +++++++++++++
 tb/tb_seg7_feed_scheduler.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_feed_scheduler_pkg.sv
// Shared types and constants for the 7-segment character feed scheduler.
package seg7_feed_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    localparam int unsigned DEF_NUM_REQ = 3;
    localparam int unsigned GRANT_W     = 3;
    localparam logic [7:0]  CH_BLANK    = 8'h00;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seg7_feed_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping modulo N.
module seg7_feed_scheduler_rr_arbiter #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             enable,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic             found;
    logic [IDX_W-1:0] pos;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        pos     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = IDX_W'((32'(ptr) + k) % N);
            if (enable && !found && req[pos]) begin
                gnt[pos] = 1'b1;
                gnt_idx  = pos;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_feed_scheduler.sv
// Round-robin arbiter that turns producer words into clean char/clear strobes
// followed by a forced low gap for the display's edge detector.
module seg7_feed_scheduler
    import seg7_feed_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
    parameter int unsigned PULSE_LEN = 2,
    parameter int unsigned GAP_LEN   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_char,
    input  logic [NUM_REQ-1:0]   req_clear,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           char_out,
    output logic                 char_valid,
    output logic                 clear_out,
    output logic                 busy,
    output logic [GRANT_W-1:0]   grant_id
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(max_u(PULSE_LEN, GAP_LEN)) + 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [7:0]         char_q, char_d;
    logic               cv_q, cv_d;
    logic               clr_q, clr_d;
    logic [GRANT_W-1:0] gid_q, gid_d;

    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               arb_en;
    logic [7:0]         sel_char;
    logic               sel_clr;

    // Grants are only offered in IDLE and never while reset is held.
    assign arb_en = (state_q == ST_IDLE) && !rst;

    seg7_feed_scheduler_rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .enable  (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        sel_char = CH_BLANK;
        sel_clr  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_char = req_char[8*i +: 8];
                sel_clr  = req_clear[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        char_d  = char_q;
        cv_d    = cv_q;
        clr_d   = clr_q;
        gid_d   = gid_q;
        case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    if (!sel_clr) begin
                        char_d = sel_char;
                    end
                    cv_d    = !sel_clr;
                    clr_d   = sel_clr;
                    gid_d   = GRANT_W'(gnt_idx);
                    ptr_d   = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    cnt_d   = CNT_W'(PULSE_LEN - 1);
                    state_d = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    cv_d    = 1'b0;
                    clr_d   = 1'b0;
                    cnt_d   = CNT_W'(GAP_LEN - 1);
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            char_q  <= CH_BLANK;
            cv_q    <= 1'b0;
            clr_q   <= 1'b0;
            gid_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            char_q  <= char_d;
            cv_q    <= cv_d;
            clr_q   <= clr_d;
            gid_q   <= gid_d;
        end
    end

    assign req_ready  = gnt;
    assign char_out   = char_q;
    assign char_valid = cv_q;
    assign clear_out  = clr_q;
    assign grant_id   = gid_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_seg7_feed_scheduler.sv
// Bench for seg7_feed_scheduler: directed scenarios with literal expectations,
// then constrained-random traffic, all compared each cycle to a timeline model.
module tb_seg7_feed_scheduler;

    localparam int N = 3;
    localparam int P = 2;
    localparam int G = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_clear, req_ready;
    logic [8*N-1:0] req_char;
    logic [7:0]     char_out;
    logic           char_valid, clear_out, busy;
    logic [2:0]     grant_id;

    int vectors = 0;
    int errors  = 0;

    // Model: m_t counts clock edges since the last accepted word.
    int         m_t, m_ptr, m_gid;
    logic [7:0] m_char;
    logic       m_clr;
    logic [N-1:0] m_gmask;

    seg7_feed_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_char   (req_char),
        .req_clear  (req_clear),
        .req_ready  (req_ready),
        .char_out   (char_out),
        .char_valid (char_valid),
        .clear_out  (clear_out),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t = P + G + 1; m_ptr = 0; m_gid = 0; m_char = 8'h00; m_clr = 1'b0; m_gmask = '0;
    endtask

    function automatic int winner();
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic bit m_busy();
        return (m_t >= 1) && (m_t <= P + G);
    endfunction

    task automatic compare_all();
        bit strobe;
        int w;
        logic [N-1:0] rdy;
        strobe = (m_t >= 1) && (m_t <= P);
        w = winner();
        rdy = '0;
        if (!rst && !m_busy() && w >= 0) rdy[w] = 1'b1;
        check("char_out", 32'(char_out), 32'(m_char));
        check("char_valid", 32'(char_valid), 32'(strobe && !m_clr));
        check("clear_out", 32'(clear_out), 32'(strobe && m_clr));
        check("busy", 32'(busy), 32'(m_busy()));
        check("grant_id", 32'(grant_id), 32'(m_gid));
        check("req_ready", 32'(req_ready), 32'(rdy));
    endtask

    task automatic model_edge();
        int w;
        m_gmask = '0;
        if (rst) begin
            model_reset();
            return;
        end
        w = winner();
        if (!m_busy() && w >= 0) begin
            m_t = 1;
            m_gid = w;
            m_ptr = (w + 1) % N;
            m_clr = req_clear[w];
            if (!m_clr) m_char = req_char[8*w +: 8];
            m_gmask[w] = 1'b1;
        end else if (m_t <= P + G) begin
            m_t++;
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic step();
        compare_all();
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] c, input logic [8*N-1:0] ch);
        req_valid = v; req_clear = c; req_char = ch;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        drive('0, '0, '0);
        settle();
        step();
        rst = 1'b0;
    endtask

    task automatic run_idle(input int n);
        drive('0, '0, req_char);
        repeat (n) begin settle(); step(); end
    endtask

    localparam logic [8*N-1:0] ABC = {8'h43, 8'h42, 8'h41};

    int           gcyc[$];
    int           gidx[$];
    logic [N-1:0] pend;
    logic [7:0]   pch [N];
    logic         pcl [N];

    initial begin
        rst = 1'b1;
        drive('0, '0, '0);
        model_reset();
        @(negedge clk);

        // Single char from requester 0
        do_reset();
        drive(3'b001, 3'b000, ABC);
        settle();
        check("t1_ready", 32'(req_ready), 32'h1);
        step();
        drive(3'b000, 3'b000, ABC);
        for (int c = 0; c < 5; c++) begin
            settle();
            check("t1_cv", 32'(char_valid), 32'(c < 2));
            check("t1_busy", 32'(busy), 32'(c < 4));
            check("t1_char", 32'(char_out), 32'h41);
            check("t1_gid", 32'(grant_id), 32'h0);
            step();
        end

        // Round-robin with all three valid
        do_reset();
        drive(3'b111, 3'b000, ABC);
        for (int c = 0; c < 16; c++) begin
            settle();
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin gcyc.push_back(c); gidx.push_back(i); end
            end
            step();
        end
        check("t2_ngrants", 32'(gidx.size()), 32'd4);
        for (int k = 0; k < 4 && k < gidx.size(); k++) begin
            check("t2_order", 32'(gidx[k]), 32'(k % 3));
            check("t2_spacing", 32'(gcyc[k]), 32'(5 * k));
        end
        run_idle(5);

        // Clear command from requester 1
        do_reset();
        drive(3'b001, 3'b000, ABC);
        settle(); step();
        run_idle(4);
        drive(3'b010, 3'b010, {8'h43, 8'h5A, 8'h41});
        settle();
        check("t3_ready", 32'(req_ready), 32'h2);
        step();
        drive(3'b000, 3'b000, ABC);
        for (int c = 0; c < 4; c++) begin
            settle();
            check("t3_clr", 32'(clear_out), 32'(c < 2));
            check("t3_cv", 32'(char_valid), 32'h0);
            check("t3_char", 32'(char_out), 32'h41);
            check("t3_gid", 32'(grant_id), 32'h1);
            step();
        end

        // Pointer wrap and skip
        do_reset();
        drive(3'b100, 3'b000, ABC);
        settle();
        check("t4_first", 32'(req_ready), 32'h4);
        step();
        run_idle(4);
        drive(3'b010, 3'b000, ABC);
        settle();
        check("t4_skip", 32'(req_ready), 32'h2);
        step();
        run_idle(4);
        drive(3'b011, 3'b000, ABC);
        settle();
        check("t4_wrap", 32'(req_ready), 32'h1);
        step();
        run_idle(5);

        // Reset in the first PULSE cycle
        do_reset();
        drive(3'b001, 3'b000, ABC);
        settle(); step();
        drive(3'b011, 3'b000, ABC);
        rst = 1'b1;
        model_reset();
        settle();
        check("t5_cv", 32'(char_valid), 32'h0);
        check("t5_busy", 32'(busy), 32'h0);
        check("t5_gid", 32'(grant_id), 32'h0);
        check("t5_ready_rst", 32'(req_ready), 32'h0);
        step();
        rst = 1'b0;
        settle();
        check("t5_ready", 32'(req_ready), 32'h1);
        step();
        drive(3'b000, 3'b000, ABC);
        settle();
        check("t5_cv_after", 32'(char_valid), 32'h1);
        step();
        run_idle(4);

        // Request withdrawn during GAP leaves pointer alone
        do_reset();
        drive(3'b001, 3'b000, ABC);
        settle(); step();
        run_idle(2);
        drive(3'b100, 3'b000, ABC);
        for (int c = 0; c < 2; c++) begin
            settle();
            check("t6_ready_gap", 32'(req_ready), 32'h0);
            step();
        end
        drive(3'b000, 3'b000, ABC);
        settle();
        check("t6_idle", 32'(busy), 32'h0);
        check("t6_cv", 32'(char_valid), 32'h0);
        step();
        drive(3'b101, 3'b000, ABC);
        settle();
        check("t6_ptr", 32'(req_ready), 32'h4);
        step();
        run_idle(5);

        // Randomised traffic
        do_reset();
        pend = '0;
        for (int i = 0; i < N; i++) begin pch[i] = 8'h00; pcl[i] = 1'b0; end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = ($urandom_range(0, 399) == 0);
            if (rst) model_reset();
            for (int i = 0; i < N; i++) begin
                if (m_gmask[i]) pend[i] = 1'b0;
                if (pend[i]) begin
                    if ($urandom_range(0, 15) == 0) pend[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    pch[i]  = 8'($urandom);
                    pcl[i]  = ($urandom_range(0, 4) == 0);
                end
            end
            for (int i = 0; i < N; i++) begin
                req_char[8*i +: 8] = pch[i];
                req_clear[i]       = pcl[i];
            end
            req_valid = pend;
            settle();
            step();
        end
        rst = 1'b0;
        run_idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
